// File: rtl/fp_accumulator.sv
// fp_accumulator: sums an in_last-terminated stream of IEEE-754 singles, presents the sum, then self-clears.
// Latency: 4 cycles per operand (IDLE->ALIGN->ADD->NORM); the sum is in OUT the cycle after the last NORM.
// Backpressure: in_ready low while busy or holding a result; out_data held stable until out_ready.
// Optional feature macro FP_ACC_RNE_EN: round-to-nearest-even (undefined: truncate toward zero).
module fp_accumulator #(
  parameter int GUARD_BITS = 3  // guard, round, sticky below the 24-bit significand (must be >= 3)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int SW = 24 + GUARD_BITS;   // aligned significand width
  localparam int LW = $clog2(SW + 1);    // leading-one position width
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  state_t        state_q;
  logic          in_ready_q, out_valid_q;
  logic [31:0]   out_data_q, acc_q, op_q;
  logic          last_q, nan_q;
  logic          big_sign_q, eff_sub_q;
  logic [7:0]    big_exp_q;
  logic [SW-1:0] big_sig_q, small_sig_q;
  logic [SW:0]   sum_q;

  // Next-state values computed from the current registers
  logic          big_sign_d, eff_sub_d;
  logic [7:0]    big_exp_d;
  logic [SW-1:0] big_sig_d, small_sig_d;
  logic [SW:0]   sum_d;
  logic [31:0]   res_d;

  // ALIGN helpers
  logic          a_zero, b_zero, a_big, sm_sticky;
  logic [30:0]   a_mag, b_mag;
  logic [SW-1:0] a_sig, b_sig, sm_sig;
  logic [7:0]    sm_exp, exp_diff;

  // NORM helpers
  logic [LW-1:0]     lead_pos, lz;
  logic [SW-1:0]     norm_m;
  logic signed [9:0] exp_n;
  logic [24:0]       mant;
  logic              g_bit, r_bit, s_bit, round_up;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Alignment: pick the larger magnitude, shift the smaller right and jam lost bits into the LSB
  always_comb begin
    a_zero     = (acc_q[30:23] == 8'd0);
    b_zero     = (op_q[30:23] == 8'd0);
    a_mag      = a_zero ? 31'd0 : acc_q[30:0];
    b_mag      = b_zero ? 31'd0 : op_q[30:0];
    a_sig      = a_zero ? '0 : {1'b1, acc_q[22:0], {GUARD_BITS{1'b0}}};
    b_sig      = b_zero ? '0 : {1'b1, op_q[22:0], {GUARD_BITS{1'b0}}};
    a_big      = (a_mag >= b_mag);
    big_sign_d = a_big ? acc_q[31] : op_q[31];
    big_exp_d  = a_big ? acc_q[30:23] : op_q[30:23];
    big_sig_d  = a_big ? a_sig : b_sig;
    sm_exp     = a_big ? op_q[30:23] : acc_q[30:23];
    sm_sig     = a_big ? b_sig : a_sig;
    eff_sub_d  = acc_q[31] ^ op_q[31];
    exp_diff   = big_exp_d - sm_exp;
    if (exp_diff > 8'(SW - 1)) begin
      // everything shifts out: the smaller operand survives only as sticky
      small_sig_d = '0;
      sm_sticky   = |sm_sig;
    end else begin
      small_sig_d = sm_sig >> exp_diff;
      sm_sticky   = |(sm_sig & ~({SW{1'b1}} << exp_diff));
    end
    small_sig_d[0] = small_sig_d[0] | sm_sticky;
  end

  // Significand add/subtract; the smaller magnitude is always the subtrahend
  always_comb begin
    sum_d = eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                      : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
  end

  // Normalise, round, then apply the zero/flush/overflow rules
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lead_pos = LW'(i);
    end
    lz    = LW'(SW - 1) - lead_pos;
    exp_n = $signed({2'b00, big_exp_q});
    if (sum_q[SW]) begin
      // carry-out: shift right by one, keeping the dropped bit as sticky
      norm_m = sum_q[SW:1] | {{(SW-1){1'b0}}, sum_q[0]};
      exp_n  = exp_n + 10'sd1;
    end else begin
      norm_m = sum_q[SW-1:0] << lz;
      exp_n  = exp_n - $signed(10'(lz));
    end
    mant  = {1'b0, norm_m[SW-1:GUARD_BITS]};
    g_bit = norm_m[GUARD_BITS-1];
    r_bit = norm_m[GUARD_BITS-2];
    s_bit = |norm_m[GUARD_BITS-3:0];
`ifdef FP_ACC_RNE_EN
    round_up = g_bit & (r_bit | s_bit | norm_m[GUARD_BITS]);
`else
    // truncation: guard/round/sticky are dropped
    round_up = 1'b0 & (g_bit | r_bit | s_bit);
`endif
    mant = mant + 25'(round_up);
    if (mant[24]) begin
      // rounding carried past the hidden bit: renormalise in place
      mant  = mant >> 1;
      exp_n = exp_n + 10'sd1;
    end
    // no hidden bit means the sum cancelled to zero
    if (!mant[23] || exp_n <= 10'sd0) begin
      res_d = 32'h0;
    end else if (exp_n >= 10'sd255) begin
      res_d = {big_sign_q, 8'hFF, 23'h0};
    end else begin
      res_d = {big_sign_q, exp_n[7:0], mant[22:0]};
    end
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      acc_q       <= 32'h0;
      op_q        <= 32'h0;
      last_q      <= 1'b0;
      nan_q       <= 1'b0;
      big_sign_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      big_exp_q   <= 8'h0;
      big_sig_q   <= '0;
      small_sig_q <= '0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= in_data;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0) nan_q <= 1'b1;
            state_q    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_sign_q  <= big_sign_d;
          big_exp_q   <= big_exp_d;
          big_sig_q   <= big_sig_d;
          small_sig_q <= small_sig_d;
          eff_sub_q   <= eff_sub_d;
          state_q     <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          acc_q <= res_d;
          if (last_q) begin
            out_data_q  <= nan_q ? QNAN : res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= 32'h0;
            nan_q       <= 1'b0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed vectors, handshake/reset corner sequences and random streams for fp_accumulator.
// Reference: exact fixed-point sum of each pair, rounded once (RNE or truncate) to single precision.
// Inputs change and outputs are sampled on the falling edge.
module tb_fp_accumulator;

`ifdef FP_ACC_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0] in_data, out_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] stream_ops [8];

  typedef struct {
    int          n;
    logic [31:0] op0, op1, op2, op3;
    logic [31:0] expv;
  } vec_t;
  vec_t vecs [NV];

  fp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Magnitude as an integer in units of 2^-80 (valid for biased exponents >= 70).
  function automatic logic [199:0] to_fix(input logic [31:0] x);
    if (x[30:23] == 8'd0) return '0;
    return {176'd0, 1'b1, x[22:0]} << (int'(x[30:23]) - 70);
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic [199:0] ma, mb, m, q, rem, half, one;
    logic s;
    int p, e, sh;
    ma = to_fix(a);
    mb = to_fix(b);
    if (a[31] == b[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb)  begin m = ma - mb; s = a[31]; end
    else                begin m = mb - ma; s = b[31]; end
    if (m == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 200; i++) if (m[i]) p = i;
    e    = p + 47;          // 2^(p-80) -> biased exponent p-80+127
    sh   = p - 23;
    one  = 1;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = one << (sh - 1);
    if (RNE && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] rand_op();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return {1'b0, 8'hFF, 23'h400000 | 23'($urandom)};
    if (r < 5)  return {1'($urandom), 8'd0, 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [31:0] res);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin
      check("out_valid timeout", {31'd0, out_valid}, 32'd1);
      res = 32'hxxxxxxxx;
    end else begin
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      res = out_data;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic run_stream(input int n, input int gap, input int hold, output logic [31:0] res);
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      send_beat(stream_ops[i], (i == n - 1));
    end
    get_result(hold, res);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] res, expv, acc;
    logic        nan;
    int          cnt, cyc, nb;

    vecs[0]  = '{n:2, op0:32'h3F800000, op1:32'h40000000, op2:0, op3:0, expv:32'h40400000};
    vecs[1]  = '{n:4, op0:32'h3D800000, op1:32'h3D800000, op2:32'h3D800000, op3:32'h3D800000, expv:32'h3E800000};
    vecs[2]  = '{n:2, op0:32'h40000000, op1:32'hC0000000, op2:0, op3:0, expv:32'h00000000};
    vecs[3]  = '{n:2, op0:32'h7F000000, op1:32'h7F000000, op2:0, op3:0, expv:32'h7F800000};
    vecs[4]  = '{n:2, op0:32'h3F800000, op1:32'h33C00000, op2:0, op3:0, expv:(RNE ? 32'h3F800001 : 32'h3F800000)};
    vecs[5]  = '{n:3, op0:32'h3F800000, op1:32'h7FC00001, op2:32'h40000000, op3:0, expv:32'h7FC00000};
    vecs[6]  = '{n:1, op0:32'h3FC00000, op1:0, op2:0, op3:0, expv:32'h3FC00000};
    vecs[7]  = '{n:1, op0:32'h00000123, op1:0, op2:0, op3:0, expv:32'h00000000};
    vecs[8]  = '{n:1, op0:32'h80000000, op1:0, op2:0, op3:0, expv:32'h00000000};
    vecs[9]  = '{n:2, op0:32'h3F800000, op1:32'hC0400000, op2:0, op3:0, expv:32'hC0000000};
    vecs[10] = '{n:2, op0:32'hFF000000, op1:32'hFF000000, op2:0, op3:0, expv:32'hFF800000};
    vecs[11] = '{n:2, op0:32'h7F800000, op1:32'h3F800000, op2:0, op3:0, expv:32'h7F800000};
    vecs[12] = '{n:2, op0:32'h3F800000, op1:32'h3F800000, op2:0, op3:0, expv:32'h40000000};
    vecs[13] = '{n:2, op0:32'h3F800000, op1:32'h33800000, op2:0, op3:0, expv:32'h3F800000};
    vecs[14] = '{n:2, op0:32'h3F800001, op1:32'h33800000, op2:0, op3:0, expv:(RNE ? 32'h3F800002 : 32'h3F800001)};
    vecs[15] = '{n:2, op0:32'h4B000000, op1:32'h3F800000, op2:0, op3:0, expv:32'h4B000001};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data",  out_data,           32'h0);

    // two beats, in_valid held high across the busy window
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    @(negedge clk);
    in_data = 32'h40000000; in_last = 1'b1;
    cnt = (!in_ready) ? 1 : 0;
    for (int k = 2; k <= 4; k++) begin @(negedge clk); if (!in_ready) cnt++; end
    check("busy cycles per beat", 32'(cnt), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 5;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check("two-beat latency", 32'(cyc), 32'd8);
    get_result(0, res);
    check("held-valid sum", res, 32'h40400000);

    // four beats: busy window after each non-final beat
    for (int b = 0; b < 4; b++) begin
      send_beat(32'h3D800000, (b == 3));
      if (b < 3) begin
        cnt = 0;
        while (!in_ready && cnt < 20) begin cnt++; @(negedge clk); end
        check($sformatf("beat%0d busy", b), 32'(cnt), 32'd3);
      end
    end
    get_result(0, res);
    check("four-beat sum", res, 32'h3E800000);

    // output held off for 5 cycles
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h3F800000, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin @(negedge clk); cnt++; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d flags", k), {30'd0, out_valid, in_ready}, 32'd2);
      check($sformatf("hold%0d data", k), out_data, 32'h40000000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release flags", {30'd0, out_valid, in_ready}, 32'd1);
    stream_ops[0] = 32'h3F800000;
    run_stream(1, 0, 0, res);
    check("after release", res, 32'h3F800000);

    // reset during ADD of a 3-beat stream
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h40000000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-rst in_ready",  {31'd0, in_ready},  32'd1);
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    stream_ops[0] = 32'h3F800000;
    run_stream(1, 0, 0, res);
    check("no residue", res, 32'h3F800000);

    // reset while a result is pending
    send_beat(32'h40000000, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin @(negedge clk); cnt++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("out-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("out-rst out_data",  out_data,           32'h0);
    stream_ops[0] = 32'h7FC00001;
    stream_ops[1] = 32'h3F800000;
    run_stream(2, 0, 1, res);
    check("nan stream", res, 32'h7FC00000);
    stream_ops[0] = 32'h3F800000;
    run_stream(1, 0, 0, res);
    check("nan flag cleared", res, 32'h3F800000);

    // directed vector table
    for (int v = 0; v < NV; v++) begin
      stream_ops[0] = vecs[v].op0;
      stream_ops[1] = vecs[v].op1;
      stream_ops[2] = vecs[v].op2;
      stream_ops[3] = vecs[v].op3;
      run_stream(vecs[v].n, v % 2, v % 3, res);
      check($sformatf("vec%0d", v), res, vecs[v].expv);
    end

    // random streams against the reference model
    for (int s = 0; s < 40; s++) begin
      nb  = $urandom_range(1, 6);
      acc = 32'h0;
      nan = 1'b0;
      for (int i = 0; i < nb; i++) begin
        if (i > 0 && $urandom_range(0, 5) == 0) stream_ops[i] = stream_ops[i-1] ^ 32'h80000001;
        else stream_ops[i] = rand_op();
        if (is_nan(stream_ops[i])) nan = 1'b1;
        else acc = model_add(acc, stream_ops[i]);
      end
      expv = nan ? 32'h7FC00000 : acc;
      run_stream(nb, $urandom_range(0, 2), $urandom_range(0, 3), res);
      check($sformatf("rand%0d", s), res, expv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
